cacheaq_dispatch: RTL and testbench

- Consumer side of the cache access-queue system.
- Watches the arbitrated queue head (pAddress/data/mask per even/odd bank, r/w/sw/fromBUS class, valid_e/valid_o, aq_isempty) and issues the request to the even and odd cache banks over independent req/ack handshakes.
- Pops the head by pulsing read for one cycle only after every required bank has acknowledged.
- Sits between cacheaqsys and the two cache bank controllers.

---
 rtl/cacheaq_dispatch.sv | 189 ++++++++++++++++++
 tb/tb_cacheaq_dispatch.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheaq_dispatch.sv
// ============================================================================
//  Module   : cacheaq_dispatch
//  Brief    : Issues the access-queue head to the even/odd cache banks over
//             independent req/ack handshakes and pops the head once all
//             required banks have acknowledged.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cacheaq_dispatch #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              hold,
   input  logic              aq_isempty,
   input  logic              valid_e,
   input  logic              valid_o,
   input  logic [ADDR_W-1:0] pAddress_e,
   input  logic [ADDR_W-1:0] pAddress_o,
   input  logic [DATA_W-1:0] data_e,
   input  logic [DATA_W-1:0] data_o,
   input  logic [DATA_W-1:0] mask_e,
   input  logic [DATA_W-1:0] mask_o,
   input  logic              r,
   input  logic              w,
   input  logic              sw,
   input  logic              fromBUS,
   input  logic              pcd,
   output logic              read,
   output logic              e_req,
   output logic              o_req,
   input  logic              e_ack,
   input  logic              o_ack,
   output logic [ADDR_W-1:0] e_addr,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] e_data,
   output logic [DATA_W-1:0] o_data,
   output logic [DATA_W-1:0] e_mask,
   output logic [DATA_W-1:0] o_mask,
   output logic [1:0]        e_op,
   output logic [1:0]        o_op,
   output logic              e_pcd,
   output logic              o_pcd,
   output logic              busy,
   output logic [15:0]       done_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WB  = 2'b01;
   localparam logic [1:0] OP_SW  = 2'b10;
   localparam logic [1:0] OP_BUS = 2'b11;

   state_t              state_q, state_d;
   logic                capture;
   logic                need_e_q, need_o_q;
   logic                e_done_q, o_done_q;
   logic                e_fin, o_fin;
   logic [ADDR_W-1:0]   e_addr_q, o_addr_q;
   logic [DATA_W-1:0]   e_data_q, o_data_q;
   logic [DATA_W-1:0]   e_mask_q, o_mask_q;
   logic [1:0]          op_q, op_d;
   logic                pcd_q;
   logic [15:0]         done_cnt_q;

   // r is the implied class when no other class bit is set; it never steers op.
   logic unused_class;
   assign unused_class = r;

   // fromBUS wins if the class one-hot is ever violated.
   always_comb begin
      op_d = OP_RD;
      if (fromBUS)
         op_d = OP_BUS;
      else if (w)
         op_d = OP_WB;
      else if (sw)
         op_d = OP_SW;
   end

   assign e_req = (state_q == S_ISSUE) && need_e_q && !e_done_q;
   assign o_req = (state_q == S_ISSUE) && need_o_q && !o_done_q;

   // A bank is finished if not needed, already acked, or acking right now.
   assign e_fin = !need_e_q || e_done_q || (e_req && e_ack);
   assign o_fin = !need_o_q || o_done_q || (o_req && o_ack);

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!aq_isempty && !hold) begin
               capture = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (e_fin && o_fin)
               state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         need_e_q <= 1'b0;
         need_o_q <= 1'b0;
         e_addr_q <= '0;
         o_addr_q <= '0;
         e_data_q <= '0;
         o_data_q <= '0;
         e_mask_q <= '0;
         o_mask_q <= '0;
         op_q     <= OP_RD;
         pcd_q    <= 1'b0;
      end else if (capture) begin
         need_e_q <= valid_e;
         need_o_q <= valid_o;
         e_addr_q <= pAddress_e;
         o_addr_q <= pAddress_o;
         e_data_q <= data_e;
         o_data_q <= data_o;
         e_mask_q <= mask_e;
         o_mask_q <= mask_o;
         op_q     <= op_d;
         pcd_q    <= pcd;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         e_done_q <= 1'b0;
         o_done_q <= 1'b0;
      end else if (capture) begin
         e_done_q <= 1'b0;
         o_done_q <= 1'b0;
      end else begin
         if (e_req && e_ack)
            e_done_q <= 1'b1;
         if (o_req && o_ack)
            o_done_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         done_cnt_q <= 16'h0000;
      else if (state_q == S_DONE)
         done_cnt_q <= done_cnt_q + 16'h0001;
   end

   assign read     = (state_q == S_DONE);
   assign busy     = (state_q != S_IDLE);
   assign done_cnt = done_cnt_q;
   assign e_addr   = e_addr_q;
   assign o_addr   = o_addr_q;
   assign e_data   = e_data_q;
   assign o_data   = o_data_q;
   assign e_mask   = e_mask_q;
   assign o_mask   = o_mask_q;
   assign e_op     = op_q;
   assign o_op     = op_q;
   assign e_pcd    = pcd_q;
   assign o_pcd    = pcd_q;

endmodule

`default_nettype wire

// File: tb/tb_cacheaq_dispatch.sv
// ============================================================================
//  Module   : tb_cacheaq_dispatch
//  Brief    : Self-checking bench for cacheaq_dispatch with a pop scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cacheaq_dispatch;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 128;

   logic              clk = 1'b0;
   logic              clr;
   logic              hold, aq_isempty, valid_e, valid_o;
   logic [ADDR_W-1:0] pAddress_e, pAddress_o;
   logic [DATA_W-1:0] data_e, data_o, mask_e, mask_o;
   logic              r, w, sw, fromBUS, pcd;
   logic              read, e_req, o_req, e_ack, o_ack;
   logic [ADDR_W-1:0] e_addr, o_addr;
   logic [DATA_W-1:0] e_data, o_data, e_mask, o_mask;
   logic [1:0]        e_op, o_op;
   logic              e_pcd, o_pcd, busy;
   logic [15:0]       done_cnt;

   cacheaq_dispatch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .clr(clr), .hold(hold), .aq_isempty(aq_isempty),
      .valid_e(valid_e), .valid_o(valid_o),
      .pAddress_e(pAddress_e), .pAddress_o(pAddress_o),
      .data_e(data_e), .data_o(data_o), .mask_e(mask_e), .mask_o(mask_o),
      .r(r), .w(w), .sw(sw), .fromBUS(fromBUS), .pcd(pcd),
      .read(read), .e_req(e_req), .o_req(o_req), .e_ack(e_ack), .o_ack(o_ack),
      .e_addr(e_addr), .o_addr(o_addr), .e_data(e_data), .o_data(o_data),
      .e_mask(e_mask), .o_mask(o_mask), .e_op(e_op), .o_op(o_op),
      .e_pcd(e_pcd), .o_pcd(o_pcd), .busy(busy), .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] ae, ao;
      logic [DATA_W-1:0] dat_e, dat_o, msk_e, msk_o;
      logic [1:0]        op;
      logic              pcd;
      logic [15:0]       cnt;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] exp_cnt;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drive a head entry and record what its pop should expose.
   task automatic present(input logic ve, input logic vo, input logic [3:0] cls,
                          input logic [ADDR_W-1:0] ae, input logic [ADDR_W-1:0] ao,
                          input logic p);
      exp_t e;
      valid_e = ve;  valid_o = vo;
      {fromBUS, sw, w, r} = cls;
      pAddress_e = ae;  pAddress_o = ao;
      data_e = rnd128();  data_o = rnd128();
      mask_e = rnd128();  mask_o = rnd128();
      pcd = p;
      aq_isempty = 1'b0;
      e.ae = ae;  e.ao = ao;
      e.dat_e = data_e;  e.dat_o = data_o;
      e.msk_e = mask_e;  e.msk_o = mask_o;
      e.op  = cls[3] ? 2'b11 : cls[1] ? 2'b01 : cls[2] ? 2'b10 : 2'b00;
      e.pcd = p;
      e.cnt = exp_cnt;
      exp_cnt = exp_cnt + 16'd1;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (clr && read) begin
         if (sb.size() == 0) begin
            chk("read_unexpected", 1'b1, 1'b0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_e_addr", e_addr, e.ae);
            chk("sb_o_addr", o_addr, e.ao);
            chk("sb_e_data", e_data, e.dat_e);
            chk("sb_o_data", o_data, e.dat_o);
            chk("sb_e_mask", e_mask, e.msk_e);
            chk("sb_o_mask", o_mask, e.msk_o);
            chk("sb_e_op", e_op, e.op);
            chk("sb_o_op", o_op, e.op);
            chk("sb_pcd", {e_pcd, o_pcd}, {e.pcd, e.pcd});
            chk("sb_cnt", done_cnt, e.cnt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clr = 1'b0;  hold = 1'b0;  aq_isempty = 1'b1;
      valid_e = 1'b0;  valid_o = 1'b0;
      pAddress_e = '0;  pAddress_o = '0;
      data_e = '0;  data_o = '0;  mask_e = '0;  mask_o = '0;
      r = 1'b0;  w = 1'b0;  sw = 1'b0;  fromBUS = 1'b0;  pcd = 1'b0;
      e_ack = 1'b0;  o_ack = 1'b0;
      exp_cnt = 16'd0;

      // Reset values
      repeat (3) tick();
      @(negedge clk);
      chk("rst_outs", {read, e_req, o_req, busy}, 4'b0000);
      chk("rst_cnt", done_cnt, 16'h0);
      chk("rst_regs", {e_addr, o_addr, e_op, o_op, e_pcd, o_pcd}, '0);
      chk("rst_data", e_data | o_data | e_mask | o_mask, '0);
      tick();
      clr = 1'b1;

      // Even-only read, ack in first ISSUE cycle
      tick();
      present(1'b1, 1'b0, 4'b0001, 15'h1A2B, 15'h0111, 1'b1);
      @(negedge clk);
      chk("A_c0_idle", {busy, e_req, read}, 3'b000);
      tick();  aq_isempty = 1'b1;  e_ack = 1'b1;
      @(negedge clk);
      chk("A_c1_req", {e_req, o_req, read, busy}, 4'b1001);
      chk("A_c1_addr", e_addr, 15'h1A2B);
      chk("A_c1_op", e_op, 2'b00);
      tick();  e_ack = 1'b0;
      @(negedge clk);
      chk("A_c2_read", {read, e_req, o_req}, 3'b100);
      tick();
      @(negedge clk);
      chk("A_c3", {read, busy}, 2'b00);
      chk("A_cnt", done_cnt, 16'd1);

      // Split write: even acks at cycle1, odd at cycle4
      tick();
      present(1'b1, 1'b1, 4'b0010, 15'h2222, 15'h3333, 1'b0);
      tick();  aq_isempty = 1'b1;  e_ack = 1'b1;
      @(negedge clk);
      chk("B_c1_req", {e_req, o_req}, 2'b11);
      tick();  e_ack = 1'b0;
      @(negedge clk);
      chk("B_c2", {e_req, o_req, read}, 3'b010);
      tick();
      @(negedge clk);
      chk("B_c3", {e_req, o_req, read}, 3'b010);
      tick();  o_ack = 1'b1;
      @(negedge clk);
      chk("B_c4", {e_req, o_req, read}, 3'b010);
      chk("B_c4_op", o_op, 2'b01);
      chk("B_c4_addr", o_addr, 15'h3333);
      tick();  o_ack = 1'b0;
      @(negedge clk);
      chk("B_c5_read", {read, e_req, o_req}, 3'b100);
      tick();
      @(negedge clk);
      chk("B_c6", {read, busy}, 2'b00);
      chk("B_cnt", done_cnt, 16'd2);

      // Bus fill (sw also set, fromBUS must win), simultaneous acks
      tick();
      present(1'b1, 1'b1, 4'b1100, 15'h4444, 15'h5555, 1'b1);
      tick();  aq_isempty = 1'b1;  e_ack = 1'b1;  o_ack = 1'b1;
      @(negedge clk);
      chk("C_c1_req", {e_req, o_req}, 2'b11);
      chk("C_c1_op", {e_op, o_op}, 4'b1111);
      tick();  e_ack = 1'b0;  o_ack = 1'b0;
      @(negedge clk);
      chk("C_c2_read", read, 1'b1);
      tick();  e_ack = 1'b1;
      @(negedge clk);
      chk("C_c3_spurious", {e_req, o_req, busy, read}, 4'b0000);
      tick();  e_ack = 1'b0;
      @(negedge clk);
      chk("C_c4", {read, busy}, 2'b00);
      chk("C_cnt", done_cnt, 16'd3);

      // Empty, then hold with a head present
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge clk);
         chk("D_empty", {e_req, o_req, read, busy}, 4'b0000);
      end
      tick();  hold = 1'b1;
      present(1'b0, 1'b1, 4'b0100, 15'h0ABC, 15'h7DEF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("D_hold", {e_req, o_req, read, busy}, 4'b0000);
         tick();
      end
      hold = 1'b0;
      @(negedge clk);
      chk("D_rel_c0", {o_req, busy}, 2'b00);
      tick();  aq_isempty = 1'b1;  o_ack = 1'b1;
      @(negedge clk);
      chk("D_rel_req", {e_req, o_req}, 2'b01);
      chk("D_rel_op", o_op, 2'b10);
      tick();  o_ack = 1'b0;
      @(negedge clk);
      chk("D_read", read, 1'b1);
      tick();
      @(negedge clk);
      chk("D_cnt", done_cnt, 16'd4);

      // Null entry: no requests, discarded two cycles after capture
      tick();
      present(1'b0, 1'b0, 4'b0001, 15'h1111, 15'h2222, 1'b0);
      tick();  aq_isempty = 1'b1;
      @(negedge clk);
      chk("E_c1", {busy, e_req, o_req, read}, 4'b1000);
      tick();
      @(negedge clk);
      chk("E_c2_read", {read, e_req, o_req}, 3'b100);
      tick();
      @(negedge clk);
      chk("E_cnt", done_cnt, 16'd5);

      // Reset in the middle of an ISSUE
      tick();
      present(1'b1, 1'b0, 4'b0001, 15'h6060, 15'h0000, 1'b0);
      tick();
      @(negedge clk);
      chk("F_req", e_req, 1'b1);
      #1;  clr = 1'b0;  hold = 1'b1;
      #1;
      chk("F_async", {e_req, read, busy}, 3'b000);
      chk("F_cnt", done_cnt, 16'd0);
      sb.delete();
      exp_cnt = 16'd0;
      tick();
      clr = 1'b1;
      tick();
      @(negedge clk);
      chk("F_idle", {busy, e_req, read}, 3'b000);
      tick();
      present(1'b1, 1'b0, 4'b0001, 15'h6060, 15'h0000, 1'b0);
      hold = 1'b0;
      tick();  aq_isempty = 1'b1;  e_ack = 1'b1;
      @(negedge clk);
      chk("F_reissue", e_req, 1'b1);
      tick();  e_ack = 1'b0;
      @(negedge clk);
      chk("F_read", read, 1'b1);
      tick();

      // Counter wrap
      @(negedge clk);
      force dut.done_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.done_cnt_q;
      exp_cnt = 16'hFFFF;
      chk("G_preload", done_cnt, 16'hFFFF);
      tick();
      present(1'b1, 1'b0, 4'b0001, 15'h7FFF, 15'h0000, 1'b1);
      tick();  aq_isempty = 1'b1;  e_ack = 1'b1;
      tick();  e_ack = 1'b0;
      @(negedge clk);
      chk("G_read", read, 1'b1);
      tick();
      @(negedge clk);
      chk("G_wrap", done_cnt, 16'h0000);

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
